aes_load_ctrl: RTL

Sequencing controller for the AES byte-serial front/back end. It accepts a byte stream through a valid/ready handshake and loads 16 key bytes, then 16 plaintext bytes, through the shared 8-to-128 serial-in/parallel-out collector. It latches each 128-bit word into the core, launches the AES core and waits for completion. It then returns the 128-bit ciphertext as 16 bytes, MSB byte first, through a valid/ready output handshake.

---
 rtl/aes_load_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/aes_load_ctrl.sv
// Byte-serial sequencer for the AES core: loads key/text through the
// shared collector, launches the core and streams ciphertext back out.
module aes_load_ctrl #(
  parameter int BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         key_keep,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         sipo_en,
  output logic [7:0]   sipo_din,
  output logic         sipo_clear,
  output logic         key_latch,
  output logic         text_latch,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ct,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD_KEY   = 3'd1;
  localparam logic [2:0] KEY_LATCH  = 3'd2;
  localparam logic [2:0] LOAD_TEXT  = 3'd3;
  localparam logic [2:0] TEXT_LATCH = 3'd4;
  localparam logic [2:0] START      = 3'd5;
  localparam logic [2:0] WAIT       = 3'd6;
  localparam logic [2:0] UNLOAD     = 3'd7;

  logic [2:0]   state;
  logic [2:0]   nxt;
  logic [3:0]   cnt;
  logic [127:0] oreg;
  logic         last;
  logic         go;

  assign last = (cnt == 4'(BYTES - 1));
  // start is gated by reset so the clear cannot leak out while held in reset
  assign go   = (state == IDLE) & start & reset;

  assign in_ready   = (state == LOAD_KEY) | (state == LOAD_TEXT);
  assign sipo_en    = in_valid & in_ready;
  assign sipo_din   = in_data;
  assign sipo_clear = go | (state == KEY_LATCH) | (state == TEXT_LATCH);
  assign key_latch  = (state == KEY_LATCH);
  assign text_latch = (state == TEXT_LATCH);
  assign aes_start  = (state == START);
  assign out_valid  = (state == UNLOAD);
  assign out_data   = oreg[127:120];
  assign busy       = (state != IDLE);
  assign frame_done = (state == UNLOAD) & out_ready & last;

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:       if (start) nxt = key_keep ? LOAD_TEXT : LOAD_KEY;
      LOAD_KEY:   if (sipo_en && last) nxt = KEY_LATCH;
      KEY_LATCH:  nxt = LOAD_TEXT;
      LOAD_TEXT:  if (sipo_en && last) nxt = TEXT_LATCH;
      TEXT_LATCH: nxt = START;
      START:      nxt = WAIT;
      WAIT:       if (aes_done) nxt = UNLOAD;
      UNLOAD:     if (out_ready && last) nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  // state, byte counter and ciphertext shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      oreg  <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (start) cnt <= '0;
        LOAD_KEY, LOAD_TEXT: if (sipo_en) cnt <= last ? '0 : cnt + 4'd1;
        WAIT: if (aes_done) begin
          oreg <= aes_ct;
          cnt  <= '0;
        end
        UNLOAD: if (out_ready) begin
          oreg <= {oreg[119:0], 8'h00};
          cnt  <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
